// File: rtl/mm3_argmax_if.sv
// Handshake and memory-read bundle between mm3_argmax and its environment.
interface mm3_argmax_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned IDX_WIDTH  = 5
);
   logic                         start;
   logic [ADDR_WIDTH-1:0]        read_addr;
   logic signed [DATA_WIDTH-1:0] read_data;
   logic                         busy;
   logic                         done;
   logic [IDX_WIDTH-1:0]         max_index;
   logic signed [DATA_WIDTH-1:0] max_value;

   // Environment side: drives start and the memory read data.
   modport master (
      output start, read_data,
      input  read_addr, busy, done, max_index, max_value
   );

   // Argmax side.
   modport slave (
      input  start, read_data,
      output read_addr, busy, done, max_index, max_value
   );
endinterface

// File: rtl/mm3_argmax.sv
// Scans NUM_ENTRIES signed logits through a one-cycle registered memory read port and
// reports the index and value of the largest one with a single-cycle done pulse.
module mm3_argmax #(
   parameter int unsigned NUM_ENTRIES = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned IDX_WIDTH   = 5
) (
   input logic         clk,
   input logic         rst,
   mm3_argmax_if.slave bus_io
);

   typedef enum logic [1:0] {StIdle, StScan, StFlush, StDone} state_e;

   localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_ENTRIES - 1);

   state_e                       state_q, state_d;
   logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
   logic                         valid_q, valid_d;
   logic [IDX_WIDTH-1:0]         cmp_idx_q, cmp_idx_d;
   logic signed [DATA_WIDTH-1:0] run_max_q, run_max_d;
   logic [IDX_WIDTH-1:0]         run_idx_q, run_idx_d;
   logic [IDX_WIDTH-1:0]         max_index_q, max_index_d;
   logic signed [DATA_WIDTH-1:0] max_value_q, max_value_d;

   // State, address, running-max and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         valid_q     <= 1'b0;
         cmp_idx_q   <= '0;
         run_max_q   <= '0;
         run_idx_q   <= '0;
         max_index_q <= '0;
         max_value_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         valid_q     <= valid_d;
         cmp_idx_q   <= cmp_idx_d;
         run_max_q   <= run_max_d;
         run_idx_q   <= run_idx_d;
         max_index_q <= max_index_d;
         max_value_q <= max_value_d;
      end
   end

   // Next-state, address sequencing, running compare and result capture.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cmp_idx_d   = cmp_idx_q;
      run_max_d   = run_max_q;
      run_idx_d   = run_idx_q;
      max_index_d = max_index_q;
      max_value_d = max_value_q;
      // An address driven during SCAN is captured by the memory at the next edge, so its
      // data is present one cycle later; this delay marks that cycle.
      valid_d     = (state_q == StScan);

      unique case (state_q)
         StIdle: begin
            addr_d = '0;
            if (bus_io.start) begin
               state_d   = StScan;
               cmp_idx_d = '0;
            end
         end
         StScan: begin
            if (addr_q == LastAddr) begin
               state_d = StFlush;
            end else begin
               addr_d = addr_q + ADDR_WIDTH'(1);
            end
         end
         StFlush: begin
            state_d = StDone;
         end
         StDone: begin
            // The DONE exit edge is the first IDLE edge: a start already high here begins
            // the next scan directly, giving one scan per NUM_ENTRIES+2 cycles.
            addr_d = '0;
            if (bus_io.start) begin
               state_d   = StScan;
               cmp_idx_d = '0;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (valid_q) begin
         // Entry 0 seeds the running max; later entries need strictly greater, so ties keep
         // the lowest index.
         if (cmp_idx_q == '0 || bus_io.read_data > run_max_q) begin
            run_max_d = bus_io.read_data;
            run_idx_d = cmp_idx_q;
         end
         cmp_idx_d = cmp_idx_q + IDX_WIDTH'(1);
      end

      // Last entry is compared on the same edge that enters DONE, so take the next values.
      if (state_q == StFlush) begin
         max_index_d = run_idx_d;
         max_value_d = run_max_d;
      end
   end

   assign bus_io.read_addr = addr_q;
   assign bus_io.busy      = (state_q == StScan) || (state_q == StFlush);
   assign bus_io.done      = (state_q == StDone);
   assign bus_io.max_index = max_index_q;
   assign bus_io.max_value = max_value_q;

endmodule

// File: tb/tb_mm3_argmax.sv
// Self-checking bench for mm3_argmax: table-driven scans over several memory images, a
// scoreboard of expected results checked on each done pulse, plus hand-written sequences
// for ignored starts, back-to-back scans and reset mid-scan.
module tb_mm3_argmax;

   localparam int N = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mm3_argmax_if bus ();

   mm3_argmax dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   logic signed [31:0] mem [N];
   int cyc = 0;
   int total = 0;
   int bad = 0;
   int held_idx = 0;

   typedef struct {
      int idx;
      longint val;
      int done_cyc;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      int     mode;
      int     exp_idx;
      longint exp_val;
      bit     extra;
   } vec_t;

   // Memory model with a one-cycle registered read.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      bus.read_data <= (int'(bus.read_addr) < N) ? mem[int'(bus.read_addr)] : 32'hDEAD_BEEF;
   end

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=1 want none (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("max_index", longint'(bus.max_index), longint'(e.idx));
            check("max_value", longint'(bus.max_value), e.val);
            check("done_cycle", longint'(cyc), longint'(e.done_cyc));
            held_idx = e.idx;
         end
      end
   end

   task automatic fill_mem(input int mode);
      for (int k = 0; k < N; k++) begin
         case (mode)
            0: mem[k] = k - 16;
            1: mem[k] = 32'sd5;
            2: mem[k] = (k == 3 || k == 20) ? 32'sh7FFF_FFFF : 32'sd5;
            3: mem[k] = (k == 0) ? 32'sh8000_0000 : (k == 7) ? -32'sd5 : -32'sd100 + k;
            4: mem[k] = (k == 9) ? 32'sd1000 : k * 3;
            default: mem[k] = (k == 22) ? 32'sd500 : -k;
         endcase
      end
   endtask

   // Pulse start, push the expectation, then walk the scan checking address/busy/held result.
   task automatic do_scan(input int ei, input longint ev, input bit extra, input bit chk_addr);
      exp_t e;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      e.idx = ei;
      e.val = ev;
      e.done_cyc = cyc + N + 1;
      sb.push_back(e);
      for (int i = 0; i <= N + 1; i++) begin
         if (chk_addr) check("read_addr", longint'(bus.read_addr), longint'((i < N) ? i : N - 1));
         check("busy", longint'(bus.busy), longint'(i <= N));
         if (i <= N) check("max_index_held", longint'(bus.max_index), longint'(held_idx));
         bus.start = extra && (i == 5 || i == 20);
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      check("sb_drained", longint'(sb.size()), 0);
   endtask

   vec_t vecs [7];

   initial begin
      int c0;
      vecs[0] = '{mode: 0, exp_idx: 31, exp_val: 15, extra: 1'b0};
      vecs[1] = '{mode: 1, exp_idx: 0, exp_val: 5, extra: 1'b0};
      vecs[2] = '{mode: 2, exp_idx: 3, exp_val: 64'sh7FFF_FFFF, extra: 1'b0};
      vecs[3] = '{mode: 3, exp_idx: 7, exp_val: -5, extra: 1'b0};
      vecs[4] = '{mode: 4, exp_idx: 9, exp_val: 1000, extra: 1'b0};
      vecs[5] = '{mode: 5, exp_idx: 22, exp_val: 500, extra: 1'b0};
      vecs[6] = '{mode: 0, exp_idx: 31, exp_val: 15, extra: 1'b1};

      bus.start = 1'b0;
      fill_mem(0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_read_addr", longint'(bus.read_addr), 0);
      check("rst_busy", longint'(bus.busy), 0);
      check("rst_done", longint'(bus.done), 0);
      check("rst_max_index", longint'(bus.max_index), 0);
      check("rst_max_value", longint'(bus.max_value), 0);
      @(negedge clk);
      rst = 1'b0;

      for (int v = 0; v < 7; v++) begin
         fill_mem(vecs[v].mode);
         do_scan(vecs[v].exp_idx, vecs[v].exp_val, vecs[v].extra, v == 0);
      end

      // start held high: back-to-back scans, done every N+2 cycles
      fill_mem(3);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      c0 = cyc;
      for (int s = 0; s < 3; s++) sb.push_back('{idx: 7, val: -5, done_cyc: c0 + N + 1 + s * (N + 2)});
      while (cyc < c0 + 2 * (N + 2) + 2) @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (N + 8) @(posedge clk);
      #1;
      check("b2b_sb_drained", longint'(sb.size()), 0);

      // reset mid-scan: outputs clear at once, no done follows
      fill_mem(4);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (12) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_read_addr", longint'(bus.read_addr), 0);
      check("midrst_busy", longint'(bus.busy), 0);
      check("midrst_max_index", longint'(bus.max_index), 0);
      check("midrst_max_value", longint'(bus.max_value), 0);
      held_idx = 0;
      @(negedge clk);
      rst = 1'b0;
      repeat (N + 4) @(posedge clk);
      #1;
      check("midrst_no_done_sb", longint'(sb.size()), 0);
      do_scan(9, 1000, 1'b0, 1'b1);

      repeat (4) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
